// File: rtl/vid_mix.sv
// Video mixer: overlay compositing, colour bars, solid fill or black, selected per frame.
// Fixed two-stage pipeline; syncs and data enable are delayed to match the pixel path.
module vid_mix #(
  parameter int unsigned W    = 24,
  parameter int unsigned N    = 2,
  parameter int unsigned BARW = 160
) (
  input  logic           hdclk,
  input  logic           rstn,
  input  logic           vin_de,
  input  logic           vin_vs,
  input  logic           vin_hs,
  input  logic [W-1:0]   vin_dat,
  input  logic [N*W-1:0] ovl_dat,
  input  logic [N-1:0]   ovl_en,
  input  logic [1:0]     mode_req,
  input  logic [W-1:0]   solid,
  input  logic           mode_upd,
  output logic           vout_de,
  output logic           vout_vs,
  output logic           vout_hs,
  output logic [W-1:0]   vout_dat,
  output logic [1:0]     mode,
  output logic [15:0]    frame_cnt
);

  localparam int unsigned XMax = 8 * BARW;
  localparam int unsigned XW   = $clog2(XMax + 1);
  localparam int unsigned CW   = W / 3;
  localparam logic [XW-1:0] XMaxV  = XW'(XMax);
  localparam logic [XW-1:0] BarWV  = XW'(BARW);
  localparam logic [XW-1:0] SevenV = XW'(7);

  // Stage 1 registers
  logic           de1_q, vs1_q, hs1_q;
  logic [W-1:0]   dat1_q;
  logic [N*W-1:0] ovl1_q;
  logic [N-1:0]   en1_q;
  logic [2:0]     bar1_q;

  // Stage 2 (output) registers
  logic           de2_q, vs2_q, hs2_q;
  logic [W-1:0]   dat2_q;

  // Mode control and line position
  logic [1:0]     mode_q, pend_mode_q;
  logic [W-1:0]   solid_q, pend_solid_q;
  logic [15:0]    fcnt_q;
  logic [XW-1:0]  x_q, x_d, x_cur, x_div;
  logic [2:0]     bar_d, bar_inv;
  logic [W-1:0]   mix_pix, bar_pix, pix_d;
  logic           vs_rise, de_rise;

  // Stage-1 sync registers double as the previous-value taps for edge detection
  assign vs_rise = vin_vs & ~vs1_q;
  assign de_rise = vin_de & ~de1_q;

  always_comb begin
    x_cur = de_rise ? '0 : x_q;
    x_d   = x_q;
    if (vin_de) begin
      x_d = (x_cur == XMaxV) ? x_cur : x_cur + 1'b1;
    end
    x_div = x_cur / BarWV;
    bar_d = (x_div > SevenV) ? 3'd7 : x_div[2:0];
  end

  always_comb begin
    mix_pix = dat1_q;
    // Walk from the highest layer down so the lowest opaque index ends up selected
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (en1_q[i] && (ovl1_q[i*W +: W] != '0)) begin
        mix_pix = ovl1_q[i*W +: W];
      end
    end
    // Component k (k=0 in the low bits) is lit when bit k of (7-bar) is set
    bar_inv = 3'd7 - bar1_q;
    bar_pix = '0;
    for (int c = 0; c < 3; c++) begin
      bar_pix[c*CW +: CW] = {CW{bar_inv[c]}};
    end
    unique case (mode_q)
      2'd0:    pix_d = mix_pix;
      2'd1:    pix_d = bar_pix;
      2'd2:    pix_d = solid_q;
      default: pix_d = '0;
    endcase
  end

  always_ff @(posedge hdclk or negedge rstn) begin
    if (!rstn) begin
      de1_q        <= 1'b0;
      vs1_q        <= 1'b0;
      hs1_q        <= 1'b0;
      dat1_q       <= '0;
      ovl1_q       <= '0;
      en1_q        <= '0;
      bar1_q       <= '0;
      de2_q        <= 1'b0;
      vs2_q        <= 1'b0;
      hs2_q        <= 1'b0;
      dat2_q       <= '0;
      mode_q       <= 2'd0;
      pend_mode_q  <= 2'd0;
      solid_q      <= '0;
      pend_solid_q <= '0;
      fcnt_q       <= '0;
      x_q          <= '0;
    end else begin
      de1_q  <= vin_de;
      vs1_q  <= vin_vs;
      hs1_q  <= vin_hs;
      dat1_q <= vin_dat;
      ovl1_q <= ovl_dat;
      en1_q  <= ovl_en;
      bar1_q <= bar_d;
      x_q    <= x_d;

      if (mode_upd) begin
        pend_mode_q  <= mode_req;
        pend_solid_q <= solid;
      end
      // A strobe coinciding with the frame edge takes effect on this frame
      if (vs_rise) begin
        mode_q  <= mode_upd ? mode_req : pend_mode_q;
        solid_q <= mode_upd ? solid : pend_solid_q;
        fcnt_q  <= fcnt_q + 16'd1;
      end

      de2_q  <= de1_q;
      vs2_q  <= vs1_q;
      hs2_q  <= hs1_q;
      dat2_q <= de1_q ? pix_d : '0;
    end
  end

  assign vout_de   = de2_q;
  assign vout_vs   = vs2_q;
  assign vout_hs   = hs2_q;
  assign vout_dat  = dat2_q;
  assign mode      = mode_q;
  assign frame_cnt = fcnt_q;

endmodule
